// File: rtl/tube_arbiter.sv
// tube_arbiter: two-master (cpu, dbg) arbiter in front of the tube display
// register block. A granted access holds the tube bus for ACCESS_CYCLES
// cycles (legal range 1..15), then returns a one-cycle ack with err/rdata.
//
// Handshake: a requester raises req together with stable we/addr/wdata and
// holds it until it samples its ack high. ack is a one-cycle pulse, and err
// and rdata are valid in that same cycle. A req still high in the cycle
// after ack counts as a new request.
//
// Optional feature: define TUBE_ARB_CPU_PRIO_EN for fixed cpu priority on a
// tie. Otherwise ties are resolved round-robin on the last-granted master.
//
// state_dbg exposes the FSM state (IDLE=0, BUSY=1, ACK=2) for checkers.

module tube_arbiter #(
   parameter int ACCESS_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [2:0]  cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [2:0]  dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        cpu_ack,
   output logic        cpu_err,
   output logic [31:0] cpu_rdata,
   output logic        dbg_ack,
   output logic        dbg_err,
   output logic [31:0] dbg_rdata,
   output logic        tube_we,
   output logic [2:0]  tube_addr,
   output logic [31:0] tube_din,
   input  logic [31:0] tube_dout,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_t;

   // Final value of the BUSY counter; BUSY ends on the edge that sees it.
   localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

   state_t      state;
   logic [3:0]  busy_cnt;
   logic        owner_dbg;    // 1 = dbg owns the current access
   logic        acc_we;       // latched direction of the current access
   logic        acc_illegal;  // latched illegal-address flag

   logic        grant_dbg;
   logic        sel_we;
   logic [2:0]  sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_legal;
   logic [31:0] rd_val;

   // Winner selection: a lone requester always wins; ties go by policy.
`ifdef TUBE_ARB_CPU_PRIO_EN
   assign grant_dbg = dbg_req && !cpu_req;
`else
   logic last_dbg;            // 1 = dbg was granted last
   assign grant_dbg = dbg_req && (!cpu_req || !last_dbg);
`endif

   // Request fields of the selected winner.
   assign sel_we    = grant_dbg ? dbg_we    : cpu_we;
   assign sel_addr  = grant_dbg ? dbg_addr  : cpu_addr;
   assign sel_wdata = grant_dbg ? dbg_wdata : cpu_wdata;
   assign sel_legal = (sel_addr[2:1] == 2'b11);

   // Read data returned to the owner: only a legal read carries tube data.
   assign rd_val = (!acc_we && !acc_illegal) ? tube_dout : 32'h0;

   assign state_dbg = state;

   // FSM with all outputs registered; ack/err/tube_we default low each cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         busy_cnt    <= 4'd0;
         owner_dbg   <= 1'b0;
         acc_we      <= 1'b0;
         acc_illegal <= 1'b0;
         tube_we     <= 1'b0;
         tube_addr   <= 3'b000;
         tube_din    <= 32'h0;
         cpu_ack     <= 1'b0;
         cpu_err     <= 1'b0;
         cpu_rdata   <= 32'h0;
         dbg_ack     <= 1'b0;
         dbg_err     <= 1'b0;
         dbg_rdata   <= 32'h0;
`ifndef TUBE_ARB_CPU_PRIO_EN
         last_dbg    <= 1'b1;
`endif
      end else begin
         tube_we <= 1'b0;
         cpu_ack <= 1'b0;
         cpu_err <= 1'b0;
         dbg_ack <= 1'b0;
         dbg_err <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req || dbg_req) begin
                  owner_dbg   <= grant_dbg;
                  acc_we      <= sel_we;
                  acc_illegal <= !sel_legal;
                  tube_addr   <= sel_addr;
                  tube_din    <= sel_wdata;
                  tube_we     <= sel_we && sel_legal;
                  busy_cnt    <= 4'd0;
                  state       <= BUSY;
`ifndef TUBE_ARB_CPU_PRIO_EN
                  last_dbg    <= grant_dbg;
`endif
               end
            end
            BUSY: begin
               if (busy_cnt == LAST_CNT) begin
                  if (owner_dbg) dbg_rdata <= rd_val;
                  else           cpu_rdata <= rd_val;
                  busy_cnt <= 4'd0;
                  state    <= ACK;
               end else begin
                  busy_cnt <= busy_cnt + 4'd1;
               end
            end
            ACK: begin
               if (owner_dbg) begin
                  dbg_ack <= 1'b1;
                  dbg_err <= acc_illegal;
               end else begin
                  cpu_ack <= 1'b1;
                  cpu_err <= acc_illegal;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tube_arbiter.sv
// tb_tube_arbiter: directed vector table on an ACCESS_CYCLES=1 instance,
// a reset-mid-access sequence and a randomized run against a timeline
// model on an ACCESS_CYCLES=4 instance.

module tb_tube_arbiter;

`ifdef TUBE_ARB_CPU_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif
   localparam int AC = 4;   // access length of the second instance

   // ---------------- clock ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- instance a (ACCESS_CYCLES = 1) ----------------
   logic        reset, cpu_req, cpu_we, dbg_req, dbg_we;
   logic [2:0]  cpu_addr, dbg_addr;
   logic [31:0] cpu_wdata, dbg_wdata, tube_dout;
   logic        cpu_ack, cpu_err, dbg_ack, dbg_err, tube_we;
   logic [31:0] cpu_rdata, dbg_rdata, tube_din;
   logic [2:0]  tube_addr;
   logic [1:0]  state_dbg;

   tube_arbiter #(.ACCESS_CYCLES(1)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
      .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
      .tube_we(tube_we), .tube_addr(tube_addr), .tube_din(tube_din),
      .tube_dout(tube_dout), .state_dbg(state_dbg)
   );

   // ---------------- instance b (ACCESS_CYCLES = AC) ----------------
   logic        b_reset, b_cpu_req, b_cpu_we, b_dbg_req, b_dbg_we;
   logic [2:0]  b_cpu_addr, b_dbg_addr;
   logic [31:0] b_cpu_wdata, b_dbg_wdata, b_tube_dout;
   logic        b_cpu_ack, b_cpu_err, b_dbg_ack, b_dbg_err, b_tube_we;
   logic [31:0] b_cpu_rdata, b_dbg_rdata, b_tube_din;
   logic [2:0]  b_tube_addr;
   logic [1:0]  b_state_dbg;

   tube_arbiter #(.ACCESS_CYCLES(AC)) dut_b (
      .clk(clk), .reset(b_reset),
      .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
      .dbg_req(b_dbg_req), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
      .cpu_ack(b_cpu_ack), .cpu_err(b_cpu_err), .cpu_rdata(b_cpu_rdata),
      .dbg_ack(b_dbg_ack), .dbg_err(b_dbg_err), .dbg_rdata(b_dbg_rdata),
      .tube_we(b_tube_we), .tube_addr(b_tube_addr), .tube_din(b_tube_din),
      .tube_dout(b_tube_dout), .state_dbg(b_state_dbg)
   );

   // ---------------- bookkeeping ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      string       name;
      logic        rst;
      logic        cr, cw;  logic [2:0] ca; logic [31:0] cd;
      logic        dr, dw;  logic [2:0] da; logic [31:0] dd;
      logic [31:0] dout;
      logic        xwe;     logic [2:0] xa; logic [31:0] xdin;
      logic        xca, xce; logic [31:0] xcr;
      logic        xda, xde; logic [31:0] xdr;
   } vec_t;

   localparam int NV = 36;
   vec_t vecs [NV];

   function automatic vec_t mk(input string nm, input logic rst,
                               input logic cr, input logic cw, input logic [2:0] ca, input logic [31:0] cd,
                               input logic dr, input logic dw, input logic [2:0] da, input logic [31:0] dd,
                               input logic [31:0] dout,
                               input logic xwe, input logic [2:0] xa, input logic [31:0] xdin,
                               input logic xca, input logic xce, input logic [31:0] xcr,
                               input logic xda, input logic xde, input logic [31:0] xdr);
      vec_t v;
      v.name = nm; v.rst = rst;
      v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
      v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
      v.dout = dout;
      v.xwe = xwe; v.xa = xa; v.xdin = xdin;
      v.xca = xca; v.xce = xce; v.xcr = xcr;
      v.xda = xda; v.xde = xde; v.xdr = xdr;
      return v;
   endfunction

   task automatic fill_vecs();
      logic [2:0]  ta;
      logic [31:0] td;
      ta = PRIO ? 3'd6 : 3'd7;
      td = PRIO ? 32'h1 : 32'h2;
      //                name        rst cr cw ca    cd            dr dw da    dd            dout          xwe xa    xdin          xca xce xcr           xda xde xdr
      vecs[0]  = mk("rst0",      1, 0, 0, 3'd0, 32'h0,        0, 0, 3'd0, 32'h0,        32'h0,        0, 3'd0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0);
      vecs[1]  = mk("rst1",      1, 0, 0, 3'd0, 32'h0,        0, 0, 3'd0, 32'h0,        32'h0,        0, 3'd0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0);
      vecs[2]  = mk("wr_grant",  0, 1, 1, 3'd6, 32'h12345678, 0, 0, 3'd0, 32'h0,        32'h0,        1, 3'd6, 32'h12345678, 0, 0, 32'h0,        0, 0, 32'h0);
      vecs[3]  = mk("wr_busy",   0, 1, 1, 3'd6, 32'h12345678, 0, 0, 3'd0, 32'h0,        32'h0,        0, 3'd6, 32'h12345678, 0, 0, 32'h0,        0, 0, 32'h0);
      vecs[4]  = mk("wr_ack",    0, 1, 1, 3'd6, 32'h12345678, 0, 0, 3'd0, 32'h0,        32'h0,        0, 3'd6, 32'h12345678, 1, 0, 32'h0,        0, 0, 32'h0);
      vecs[5]  = mk("wr_idle",   0, 0, 0, 3'd0, 32'h0,        0, 0, 3'd0, 32'h0,        32'h0,        0, 3'd6, 32'h12345678, 0, 0, 32'h0,        0, 0, 32'h0);
      vecs[6]  = mk("rd_grant",  0, 0, 0, 3'd0, 32'h0,        1, 0, 3'd7, 32'hDEADBEEF, 32'hA,        0, 3'd7, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 32'h0);
      vecs[7]  = mk("rd_busy",   0, 0, 0, 3'd0, 32'h0,        1, 0, 3'd7, 32'hDEADBEEF, 32'hA,        0, 3'd7, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 32'hA);
      vecs[8]  = mk("rd_ack",    0, 0, 0, 3'd0, 32'h0,        1, 0, 3'd7, 32'hDEADBEEF, 32'h99,       0, 3'd7, 32'hDEADBEEF, 0, 0, 32'h0,        1, 0, 32'hA);
      vecs[9]  = mk("rd_idle",   0, 0, 0, 3'd0, 32'h0,        0, 0, 3'd0, 32'h0,        32'h99,       0, 3'd7, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 32'hA);
      vecs[10] = mk("cr_grant",  0, 1, 0, 3'd6, 32'h11111111, 0, 0, 3'd0, 32'h0,        32'h13579BDF, 0, 3'd6, 32'h11111111, 0, 0, 32'h0,        0, 0, 32'hA);
      vecs[11] = mk("cr_busy",   0, 1, 0, 3'd6, 32'h11111111, 0, 0, 3'd0, 32'h0,        32'h13579BDF, 0, 3'd6, 32'h11111111, 0, 0, 32'h13579BDF, 0, 0, 32'hA);
      vecs[12] = mk("cr_ack",    0, 1, 0, 3'd6, 32'h11111111, 0, 0, 3'd0, 32'h0,        32'h0,        0, 3'd6, 32'h11111111, 1, 0, 32'h13579BDF, 0, 0, 32'hA);
      vecs[13] = mk("cr_idle",   0, 0, 0, 3'd0, 32'h0,        0, 0, 3'd0, 32'h0,        32'h0,        0, 3'd6, 32'h11111111, 0, 0, 32'h13579BDF, 0, 0, 32'hA);
      vecs[14] = mk("il_grant",  0, 1, 1, 3'd2, 32'h55,       0, 0, 3'd0, 32'h0,        32'hFFFFFFFF, 0, 3'd2, 32'h55,       0, 0, 32'h13579BDF, 0, 0, 32'hA);
      vecs[15] = mk("il_busy",   0, 1, 1, 3'd2, 32'h55,       0, 0, 3'd0, 32'h0,        32'hFFFFFFFF, 0, 3'd2, 32'h55,       0, 0, 32'h0,        0, 0, 32'hA);
      vecs[16] = mk("il_ack",    0, 1, 1, 3'd2, 32'h55,       0, 0, 3'd0, 32'h0,        32'hFFFFFFFF, 0, 3'd2, 32'h55,       1, 1, 32'h0,        0, 0, 32'hA);
      vecs[17] = mk("il_idle",   0, 0, 0, 3'd0, 32'h0,        0, 0, 3'd0, 32'h0,        32'h0,        0, 3'd2, 32'h55,       0, 0, 32'h0,        0, 0, 32'hA);
      vecs[18] = mk("rst2",      1, 0, 0, 3'd0, 32'h0,        0, 0, 3'd0, 32'h0,        32'h0,        0, 3'd0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0);
      vecs[19] = mk("tie0_g",    0, 1, 1, 3'd6, 32'h1,        1, 1, 3'd7, 32'h2,        32'h0,        1, 3'd6, 32'h1,        0, 0, 32'h0,        0, 0, 32'h0);
      vecs[20] = mk("tie0_b",    0, 1, 1, 3'd6, 32'h1,        1, 1, 3'd7, 32'h2,        32'h0,        0, 3'd6, 32'h1,        0, 0, 32'h0,        0, 0, 32'h0);
      vecs[21] = mk("tie0_a",    0, 1, 1, 3'd6, 32'h1,        1, 1, 3'd7, 32'h2,        32'h0,        0, 3'd6, 32'h1,        1, 0, 32'h0,        0, 0, 32'h0);
      vecs[22] = mk("tie1_g",    0, 1, 1, 3'd6, 32'h1,        1, 1, 3'd7, 32'h2,        32'h0,        1, ta,   td,           0, 0, 32'h0,        0, 0, 32'h0);
      vecs[23] = mk("tie1_b",    0, 1, 1, 3'd6, 32'h1,        1, 1, 3'd7, 32'h2,        32'h0,        0, ta,   td,           0, 0, 32'h0,        0, 0, 32'h0);
      vecs[24] = mk("tie1_a",    0, 1, 1, 3'd6, 32'h1,        1, 1, 3'd7, 32'h2,        32'h0,        0, ta,   td,           PRIO, 0, 32'h0,     !PRIO, 0, 32'h0);
      vecs[25] = mk("tie2_g",    0, 1, 1, 3'd6, 32'h1,        1, 1, 3'd7, 32'h2,        32'h0,        1, 3'd6, 32'h1,        0, 0, 32'h0,        0, 0, 32'h0);
      vecs[26] = mk("tie2_b",    0, 1, 1, 3'd6, 32'h1,        1, 1, 3'd7, 32'h2,        32'h0,        0, 3'd6, 32'h1,        0, 0, 32'h0,        0, 0, 32'h0);
      vecs[27] = mk("tie2_a",    0, 1, 1, 3'd6, 32'h1,        1, 1, 3'd7, 32'h2,        32'h0,        0, 3'd6, 32'h1,        1, 0, 32'h0,        0, 0, 32'h0);
      vecs[28] = mk("tie_end",   0, 0, 0, 3'd0, 32'h0,        0, 0, 3'd0, 32'h0,        32'h0,        0, 3'd6, 32'h1,        0, 0, 32'h0,        0, 0, 32'h0);
      vecs[29] = mk("b2b0_g",    0, 1, 1, 3'd7, 32'hAAAA0001, 0, 0, 3'd0, 32'h0,        32'h0,        1, 3'd7, 32'hAAAA0001, 0, 0, 32'h0,        0, 0, 32'h0);
      vecs[30] = mk("b2b0_b",    0, 1, 1, 3'd7, 32'hAAAA0001, 0, 0, 3'd0, 32'h0,        32'h0,        0, 3'd7, 32'hAAAA0001, 0, 0, 32'h0,        0, 0, 32'h0);
      vecs[31] = mk("b2b0_a",    0, 1, 1, 3'd7, 32'hAAAA0001, 0, 0, 3'd0, 32'h0,        32'h0,        0, 3'd7, 32'hAAAA0001, 1, 0, 32'h0,        0, 0, 32'h0);
      vecs[32] = mk("b2b1_g",    0, 1, 1, 3'd7, 32'hAAAA0002, 0, 0, 3'd0, 32'h0,        32'h0,        1, 3'd7, 32'hAAAA0002, 0, 0, 32'h0,        0, 0, 32'h0);
      vecs[33] = mk("b2b1_b",    0, 1, 1, 3'd7, 32'hAAAA0002, 0, 0, 3'd0, 32'h0,        32'h0,        0, 3'd7, 32'hAAAA0002, 0, 0, 32'h0,        0, 0, 32'h0);
      vecs[34] = mk("b2b1_a",    0, 1, 1, 3'd7, 32'hAAAA0002, 0, 0, 3'd0, 32'h0,        32'h0,        0, 3'd7, 32'hAAAA0002, 1, 0, 32'h0,        0, 0, 32'h0);
      vecs[35] = mk("b2b_end",   0, 0, 0, 3'd0, 32'h0,        0, 0, 3'd0, 32'h0,        32'h0,        0, 3'd7, 32'hAAAA0002, 0, 0, 32'h0,        0, 0, 32'h0);
   endtask

   task automatic run_table();
      for (int i = 0; i < NV; i++) begin
         reset = vecs[i].rst;
         cpu_req = vecs[i].cr; cpu_we = vecs[i].cw; cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cd;
         dbg_req = vecs[i].dr; dbg_we = vecs[i].dw; dbg_addr = vecs[i].da; dbg_wdata = vecs[i].dd;
         tube_dout = vecs[i].dout;
         @(posedge clk);
         #1;
         n_vec++;
         chk({vecs[i].name, ".tube_we"},   tube_we,   vecs[i].xwe);
         chk({vecs[i].name, ".tube_addr"}, tube_addr, vecs[i].xa);
         chk({vecs[i].name, ".tube_din"},  tube_din,  vecs[i].xdin);
         chk({vecs[i].name, ".cpu_ack"},   cpu_ack,   vecs[i].xca);
         chk({vecs[i].name, ".cpu_err"},   cpu_err,   vecs[i].xce);
         chk({vecs[i].name, ".cpu_rdata"}, cpu_rdata, vecs[i].xcr);
         chk({vecs[i].name, ".dbg_ack"},   dbg_ack,   vecs[i].xda);
         chk({vecs[i].name, ".dbg_err"},   dbg_err,   vecs[i].xde);
         chk({vecs[i].name, ".dbg_rdata"}, dbg_rdata, vecs[i].xdr);
      end
   endtask

   // ---------------- reset in the middle of an access (instance b) ----------------
   task automatic run_mid_reset();
      int lat;
      b_reset = 1'b1;
      b_cpu_req = 1'b0; b_dbg_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      b_reset = 1'b0;
      b_cpu_req = 1'b1; b_cpu_we = 1'b1; b_cpu_addr = 3'd6; b_cpu_wdata = 32'hCAFE0001;
      @(posedge clk); #1;
      n_vec++;
      chk("mid.first_busy_we", b_tube_we, 1'b1);
      @(posedge clk); #1;
      n_vec++;
      chk("mid.second_busy_we", b_tube_we, 1'b0);
      b_reset = 1'b1;
      b_cpu_req = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      chk("mid.rst_we",    b_tube_we,   1'b0);
      chk("mid.rst_addr",  b_tube_addr, 3'd0);
      chk("mid.rst_din",   b_tube_din,  32'h0);
      chk("mid.rst_cack",  b_cpu_ack,   1'b0);
      chk("mid.rst_cerr",  b_cpu_err,   1'b0);
      chk("mid.rst_crd",   b_cpu_rdata, 32'h0);
      chk("mid.rst_dack",  b_dbg_ack,   1'b0);
      chk("mid.rst_derr",  b_dbg_err,   1'b0);
      chk("mid.rst_drd",   b_dbg_rdata, 32'h0);
      b_reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         n_vec++;
         chk("mid.no_ack", b_cpu_ack, 1'b0);
         chk("mid.no_we",  b_tube_we, 1'b0);
      end
      // next request served normally: read of 3'b111
      b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 3'd7; b_cpu_wdata = 32'h0;
      b_tube_dout = 32'h0000000F;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (b_cpu_ack === 1'b1) begin
            lat = k;
            break;
         end
      end
      n_vec++;
      chk("mid.next_latency", lat, AC + 2);
      chk("mid.next_rdata",   b_cpu_rdata, 32'hF);
      chk("mid.next_err",     b_cpu_err,   1'b0);
      b_cpu_req = 1'b0;
      @(posedge clk); #1;
   endtask

   // ---------------- timeline reference model (instance b) ----------------
   // An access granted at edge g: tube signals show it after g, the owner's
   // rdata is refreshed at edge g+AC, the ack shows after g+AC+1, and the
   // next grant can happen at g+AC+2.
   bit          m_busy;
   int          m_g;
   bit          m_w;          // 0 = cpu, 1 = dbg
   bit          m_we;
   bit          m_ill;
   bit          m_last_dbg;
   logic        e_twe;
   logic [2:0]  e_ta;
   logic [31:0] e_td;
   logic [1:0]  e_ack, e_err;
   logic [31:0] e_rd [2];
   logic [33:0] exp_q [$];   // {owner, err, rdata} of completions to come

   task automatic model_reset();
      m_busy = 1'b0; m_last_dbg = 1'b1;
      e_twe = 1'b0; e_ta = 3'd0; e_td = 32'h0;
      e_ack = 2'b00; e_err = 2'b00;
      e_rd[0] = 32'h0; e_rd[1] = 32'h0;
      exp_q.delete();
   endtask

   task automatic model_edge(input int n);
      int k;
      bit w;
      if (b_reset) begin
         model_reset();
         return;
      end
      e_twe = 1'b0; e_ack = 2'b00; e_err = 2'b00;
      if (m_busy) begin
         k = n - m_g;
         if (k == AC) begin
            e_rd[m_w] = (!m_we && !m_ill) ? b_tube_dout : 32'h0;
            exp_q.push_back({m_w, m_ill, e_rd[m_w]});
         end
         if (k == AC + 1) begin
            e_ack[m_w] = 1'b1;
            e_err[m_w] = m_ill;
            m_busy = 1'b0;
         end
      end else if (b_cpu_req || b_dbg_req) begin
         if (b_cpu_req && b_dbg_req) w = PRIO ? 1'b0 : !m_last_dbg;
         else                        w = b_dbg_req;
         m_w = w; m_last_dbg = w; m_g = n; m_busy = 1'b1;
         m_we = w ? b_dbg_we   : b_cpu_we;
         e_ta = w ? b_dbg_addr  : b_cpu_addr;
         e_td = w ? b_dbg_wdata : b_cpu_wdata;
         m_ill = !(e_ta == 3'd6 || e_ta == 3'd7);
         e_twe = m_we && !m_ill;
      end
   endtask

   task automatic next_req(input logic req, input logic ack, input logic quiet,
                           input logic cwe, input logic [2:0] caddr, input logic [31:0] cwd,
                           output logic nreq, output logic nwe, output logic [2:0] naddr, output logic [31:0] nwd);
      bit fresh;
      nreq = req; nwe = cwe; naddr = caddr; nwd = cwd;
      fresh = 1'b0;
      if (quiet) begin
         if (ack) nreq = 1'b0;
      end else if (req) begin
         if (ack) begin
            if ($urandom_range(0, 3) != 0) nreq = 1'b0;
            else fresh = 1'b1;
         end else if ($urandom_range(0, 31) == 0) begin
            nreq = 1'b0;
         end
      end else if ($urandom_range(0, 2) == 0) begin
         nreq = 1'b1;
         fresh = 1'b1;
      end
      if (fresh) begin
         nwe = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) naddr = 3'($urandom_range(0, 7));
         else                           naddr = {2'b11, 1'($urandom_range(0, 1))};
         nwd = $urandom;
      end
   endtask

   task automatic run_random(input int ncyc);
      logic [33:0] got;
      bit quiet;
      b_reset = 1'b1;
      b_cpu_req = 1'b0; b_dbg_req = 1'b0;
      for (int n = 0; n < ncyc; n++) begin
         quiet = (n >= ncyc - 40);
         @(posedge clk);
         model_edge(n);
         #1;
         n_vec++;
         chk("rnd.tube_we",   b_tube_we,   e_twe);
         chk("rnd.tube_addr", b_tube_addr, e_ta);
         chk("rnd.tube_din",  b_tube_din,  e_td);
         chk("rnd.cpu_ack",   b_cpu_ack,   e_ack[0]);
         chk("rnd.cpu_err",   b_cpu_err,   e_err[0]);
         chk("rnd.cpu_rdata", b_cpu_rdata, e_rd[0]);
         chk("rnd.dbg_ack",   b_dbg_ack,   e_ack[1]);
         chk("rnd.dbg_err",   b_dbg_err,   e_err[1]);
         chk("rnd.dbg_rdata", b_dbg_rdata, e_rd[1]);
         if (b_cpu_ack === 1'b1 || b_dbg_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("rnd.sb_unexpected_ack", 1'b1, 1'b0);
            end else begin
               got = {b_dbg_ack, (b_dbg_ack ? b_dbg_err : b_cpu_err), (b_dbg_ack ? b_dbg_rdata : b_cpu_rdata)};
               chk("rnd.sb_owner", got[33], exp_q[0][33]);
               chk("rnd.sb_err",   got[32], exp_q[0][32]);
               chk("rnd.sb_rdata", got[31:0], exp_q[0][31:0]);
               void'(exp_q.pop_front());
            end
         end
         if (n_err > 20) break;
         // next inputs
         b_reset = (!quiet && $urandom_range(0, 199) == 0);
         b_tube_dout = $urandom;
         next_req(b_cpu_req, b_cpu_ack, quiet, b_cpu_we, b_cpu_addr, b_cpu_wdata,
                  b_cpu_req, b_cpu_we, b_cpu_addr, b_cpu_wdata);
         next_req(b_dbg_req, b_dbg_ack, quiet, b_dbg_we, b_dbg_addr, b_dbg_wdata,
                  b_dbg_req, b_dbg_we, b_dbg_addr, b_dbg_wdata);
         if (quiet && n == ncyc - 40) begin
            b_cpu_req = 1'b0;
            b_dbg_req = 1'b0;
         end
      end
      n_vec++;
      chk("rnd.sb_drained", exp_q.size(), 0);
   endtask

   // ---------------- main ----------------
   initial begin
      reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 3'd0; cpu_wdata = 32'h0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 3'd0; dbg_wdata = 32'h0;
      tube_dout = 32'h0;
      b_reset = 1'b1;
      b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = 3'd0; b_cpu_wdata = 32'h0;
      b_dbg_req = 1'b0; b_dbg_we = 1'b0; b_dbg_addr = 3'd0; b_dbg_wdata = 32'h0;
      b_tube_dout = 32'h0;
      model_reset();

      fill_vecs();
      run_table();
      run_mid_reset();
      run_random(3000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
